// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NREQ producers, the arbiter and one FIFO port.
// slave = arbiter side, master = producer/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req_i;
    logic [NREQ*WIDTH-1:0] wdata_i;
    logic [NREQ-1:0]       gnt_o;
    logic [NREQ-1:0]       ack_o;
    logic                  fifo_wr_en_o;
    logic [WIDTH-1:0]      fifo_wdata_o;
    logic                  fifo_full_i;
    logic [15:0]           stall_cnt_o;

    modport slave (
        input  req_i, wdata_i, fifo_full_i,
        output gnt_o, ack_o, fifo_wr_en_o, fifo_wdata_o, stall_cnt_o
    );

    modport master (
        output req_i, wdata_i, fifo_full_i,
        input  gnt_o, ack_o, fifo_wr_en_o, fifo_wdata_o, stall_cnt_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// Optional: define FIFO_ARB_STALL_CNT_EN to build the full-stall counter.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [3:0]      bcnt_q, bcnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;
    logic            own_req;
    logic            wr_en;
    logic [WIDTH-1:0] own_data;

    // Round-robin pick: first requester after last, lowest distance wins
    always_comb begin
        pick = last_q;
        idx  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IW'((int'(last_q) + i) % NREQ);
            if (bus.req_i[idx]) pick = idx;
        end
    end

    // Owner request and data steering
    always_comb begin
        own_req  = 1'b0;
        own_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner_q == IW'(k)) begin
                own_req  = bus.req_i[k];
                own_data = bus.wdata_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign wr_en = (state_q == S_BURST) && own_req && !bus.fifo_full_i;

    // Next-state: arbitrate in IDLE, count writes and release in BURST
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (|bus.req_i) begin
                    state_d = S_BURST;
                    owner_d = pick;
                    bcnt_d  = '0;
                    gnt_d   = NREQ'(1) << pick;
                end
            end
            S_BURST: begin
                if (wr_en) bcnt_d = bcnt_q + 4'd1;
                if ((wr_en && bcnt_q == 4'(MAX_BURST - 1)) || !own_req) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    last_d  = owner_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            bcnt_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.gnt_o        = gnt_q;
    assign bus.ack_o        = wr_en ? gnt_q : '0;
    assign bus.fifo_wr_en_o = wr_en;
    assign bus.fifo_wdata_o = (state_q == S_BURST) ? own_data : '0;

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] stall_q;

    // Count cycles the owner wants to write but the FIFO is full
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (state_q == S_BURST && own_req && bus.fifo_full_i
                     && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt_o = stall_q;
`else
    assign bus.stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized self-checking bench for fifo_wr_arbiter.
// Reference model tracks producers, grant owner and burst count.
module tb_fifo_wr_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int MB   = 4;
`ifdef FIFO_ARB_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

    fifo_wr_arbiter #(
        .NREQ(NREQ), .WIDTH(W), .MAX_BURST(MB)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // producers
    int         pend[NREQ];
    logic [7:0] dat[NREQ];
    int         ackcnt[NREQ];

    // reference model
    bit busy;
    int own;
    int cnt;
    int last;
    int stall_m;

    logic [7:0]  wlog[$];
    int          grants[$];
    logic [9:0]  wrpat;
    logic [3:0]  prevg;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        busy    = 1'b0;
        own     = 0;
        cnt     = 0;
        last    = NREQ - 1;
        stall_m = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input bit fl);
        bit wr;
        int c;
        if (!busy) begin
            if (r != 0) begin
                for (int i = 1; i <= NREQ; i++) begin
                    c = (last + i) % NREQ;
                    if (r[c]) begin
                        own = c;
                        break;
                    end
                end
                busy = 1'b1;
                cnt  = 0;
            end
        end else begin
            wr = r[own] && !fl;
            if (r[own] && fl && stall_m < 65535) stall_m++;
            if (wr) cnt++;
            if ((wr && cnt == MB) || !r[own]) begin
                busy = 1'b0;
                last = own;
            end
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            bus.req_i[k]         = (pend[k] > 0);
            bus.wdata_i[k*W +: W] = dat[k];
        end
    endtask

    // one clock cycle: drive, check mid-cycle, model edge, producers react
    task automatic step(input bit fl);
        logic [3:0] eg;
        logic       ew;
        logic [7:0] ed;
        logic [3:0] ackd;
        logic [3:0] r;
        bus.fifo_full_i = fl;
        drive();
        r = bus.req_i;
        #4;
        eg = busy ? 4'(1 << own) : 4'd0;
        ew = busy && r[own] && !fl;
        ed = busy ? dat[own] : 8'd0;
        chk("gnt", 32'(bus.gnt_o), 32'(eg));
        chk("wr_en", 32'(bus.fifo_wr_en_o), 32'(ew));
        chk("ack", 32'(bus.ack_o), ew ? 32'(eg) : 32'd0);
        chk("wdata", 32'(bus.fifo_wdata_o), 32'(ed));
        chk("stall", 32'(bus.stall_cnt_o), STALL_EN ? 32'(stall_m) : 32'd0);
        if (bus.fifo_wr_en_o === 1'b1) wlog.push_back(bus.fifo_wdata_o);
        wrpat = {wrpat[8:0], bus.fifo_wr_en_o};
        if (prevg == 0 && bus.gnt_o != 0) begin
            for (int k = 0; k < NREQ; k++)
                if (bus.gnt_o[k]) grants.push_back(k);
        end
        prevg = bus.gnt_o;
        ackd  = bus.ack_o;
        @(posedge clk);
        model_edge(r, fl);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (ackd[k] === 1'b1) begin
                dat[k] = dat[k] + 8'd1;
                pend[k]--;
                ackcnt[k]++;
            end
        end
    endtask

    function automatic bit all_quiet();
        bit q;
        q = (bus.gnt_o == 0);
        for (int k = 0; k < NREQ; k++) if (pend[k] != 0) q = 1'b0;
        return q;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b0;
        bus.req_i       = '0;
        bus.wdata_i     = '0;
        bus.fifo_full_i = 1'b0;
        wrpat           = '0;
        prevg           = '0;
        for (int k = 0; k < NREQ; k++) begin
            pend[k]   = 0;
            dat[k]    = 8'h00;
            ackcnt[k] = 0;
        end
        model_reset();

        #3;
        chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("rst_ack", 32'(bus.ack_o), 32'd0);
        chk("rst_wr", 32'(bus.fifo_wr_en_o), 32'd0);
        chk("rst_wdata", 32'(bus.fifo_wdata_o), 32'd0);
        chk("rst_stall", 32'(bus.stall_cnt_o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // full stall on producer 1's second write
        pend[1] = 4;
        dat[1]  = 8'h10;
        wlog.delete();
        step(0);
        step(0);
        repeat (5) step(1);
        repeat (4) step(0);
        chk("fs_writes", 32'(wlog.size()), 32'd4);
        chk("fs_stall", 32'(bus.stall_cnt_o), STALL_EN ? 32'd5 : 32'd0);
        chk("fs_idle", 32'(bus.gnt_o), 32'd0);

        // single producer, 6 words
        pend[2] = 6;
        dat[2]  = 8'hA0;
        wlog.delete();
        ackcnt[2] = 0;
        wrpat = '0;
        repeat (10) step(0);
        chk("sp_pattern", 32'(wrpat), 32'(10'b0111101100));
        chk("sp_acks", 32'(ackcnt[2]), 32'd6);
        for (int i = 0; i < 6; i++)
            chk("sp_data", 32'(wlog[i]), 32'(8'hA0 + i));

        // early release by producer 3
        pend[3] = 2;
        dat[3]  = 8'h30;
        repeat (3) step(0);
        pend[0] = 3;
        pend[1] = 3;
        step(0);
        chk("er_exit", 32'(bus.gnt_o), 32'd0);
        step(0);
        chk("er_next", 32'(bus.gnt_o), 32'd1);
        for (int t = 0; t < 100; t++) begin
            if (all_quiet()) break;
            step(0);
        end
        chk("er_drain", 32'(all_quiet()), 32'd1);

        // async reset mid-burst, then round robin from producer 0
        for (int k = 0; k < NREQ; k++) begin
            pend[k] = 8;
            dat[k]  = 8'(k * 16 + 8'h40);
        end
        repeat (3) step(0);
        #4 rst_n = 1'b0;
        #1;
        chk("ar_gnt", 32'(bus.gnt_o), 32'd0);
        chk("ar_wr", 32'(bus.fifo_wr_en_o), 32'd0);
        chk("ar_ack", 32'(bus.ack_o), 32'd0);
        model_reset();
        prevg = '0;
        grants.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (24) step(0);
        chk("rr_n", 32'(grants.size() >= 5), 32'd1);
        chk("rr_0", 32'(grants[0]), 32'd0);
        chk("rr_1", 32'(grants[1]), 32'd1);
        chk("rr_2", 32'(grants[2]), 32'd2);
        chk("rr_3", 32'(grants[3]), 32'd3);
        chk("rr_4", 32'(grants[4]), 32'd0);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (pend[k] == 0 && $urandom_range(7) == 0) begin
                    pend[k] = int'($urandom_range(9, 1));
                    dat[k]  = 8'($urandom);
                end else if (pend[k] > 0 && $urandom_range(39) == 0) begin
                    pend[k] = 0;
                end
            end
            step($urandom_range(3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
